wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter_pkg : shared register-file widths, entry type, grant sources  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int DATA_W     = 32;
  localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_fifo : load-result FIFO, power-of-two depth, occupancy/full/empty     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter : register-file write-back arbiter, ALU vs buffered loads     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_stall,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_ADDR_W-1:0]  lu_addr,
  input  logic [DATA_W-1:0]      lu_data,
  output logic                   we,
  output logic [REG_ADDR_W-1:0]  wa,
  output logic [DATA_W-1:0]      wd,
  output logic [$clog2(DEPTH):0] lu_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  wb_entry_t             alu_entry, lu_entry, head, grant;
  wb_src_e               src;
  logic                  fifo_full, fifo_empty, push, pop, fifo_wr;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0]     wd_q, wd_d;

  assign alu_entry = {alu_addr, alu_data};
  assign lu_entry  = {lu_addr, lu_data};
  assign lu_ready  = !fifo_full;
  assign push      = lu_valid && lu_ready;
  assign pop       = (src == SRC_FIFO);
  assign fifo_wr   = push && (src != SRC_BYPASS);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_wr),
    .pop_i   (pop),
    .wdata_i (lu_entry),
    .rdata_o (head),
    .count_o (lu_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A stall forces the head out; a bypass is only legal with the FIFO empty.
  always_comb begin
    src = SRC_NONE;
    if (!fifo_empty && (stall_q || !alu_valid)) src = SRC_FIFO;
    else if (alu_valid && !stall_q)             src = SRC_ALU;
    else if (push)                              src = SRC_BYPASS;
  end

  always_comb begin
    case (src)
      SRC_ALU:    grant = alu_entry;
      SRC_FIFO:   grant = head;
      SRC_BYPASS: grant = lu_entry;
      default:    grant = '0;
    endcase
    we_d = (src != SRC_NONE) && (grant.addr != ZERO_REG);
    wa_d = we_d ? grant.addr : wa_q;
    wd_d = we_d ? grant.data : wd_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty)
      starve_d = '0;
    else if (src == SRC_ALU && starve_q != STARVE_MAX)
      starve_d = starve_q + STARVE_ONE;
    stall_d = (starve_d == STARVE_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign alu_stall = stall_q;
  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter : directed and random self-checking bench for wb_arbiter   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid, lu_valid;
  logic [5:0]  alu_addr, lu_addr;
  logic [31:0] alu_data, lu_data;
  logic        alu_stall, lu_ready, we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [2:0]  lu_count;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .lu_count  (lu_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending load queue {addr,data}, starvation count, stall.
  logic [37:0] mq[$];
  logic [31:0] ld_sb[$];
  int          m_starve = 0;
  bit          m_stall  = 1'b0;
  int unsigned seq      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [5:0] la, input logic [31:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lu_valid  = lv; lu_addr  = la; lu_data  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(input bit idle);
    logic        av, lv;
    logic [5:0]  aa, la;
    logic [31:0] ad, ld;
    logic [37:0] g;
    logic [31:0] front;
    bit          granted, popped, alu_win, push, was_empty, exp_we;
    int          qsz;
    av = !idle && ($urandom_range(0, 9) < 6);
    aa = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    ad = $urandom() & 32'h7FFF_FFFF;
    lv = !idle && ($urandom_range(0, 9) < 5);
    la = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    ld = 32'h8000_0000 | seq;
    seq++;
    drive(av, aa, ad, lv, la, ld);
    #1;
    qsz = mq.size();
    check("rnd_stall", alu_stall, m_stall);
    check("rnd_count", lu_count, qsz);
    check("rnd_ready", lu_ready, qsz < DEPTH);

    g = '0; granted = 0; popped = 0; alu_win = 0;
    was_empty = (qsz == 0);
    push = lv && (qsz < DEPTH);
    if (m_stall && !was_empty) begin
      g = mq.pop_front(); popped = 1; granted = 1;
    end else if (av && !m_stall) begin
      g = {aa, ad}; alu_win = 1; granted = 1;
    end else if (!was_empty) begin
      g = mq.pop_front(); popped = 1; granted = 1;
    end else if (push) begin
      g = {la, ld}; granted = 1; push = 0;
      if (la != 6'd0) ld_sb.push_back(ld);
    end
    if (push) begin
      mq.push_back({la, ld});
      if (la != 6'd0) ld_sb.push_back(ld);
    end
    if (popped || was_empty) m_starve = 0;
    else if (alu_win && m_starve < STARVE_LIMIT) m_starve++;
    m_stall = (m_starve == STARVE_LIMIT);
    exp_we = granted && (g[37:32] != 6'd0);

    tick();
    check("rnd_we", we, exp_we);
    if (exp_we) begin
      check("rnd_wa", wa, g[37:32]);
      check("rnd_wd", wd, g[31:0]);
    end
    if (we && wd[31]) begin
      check("rnd_ld_pending", ld_sb.size() != 0, 1);
      if (ld_sb.size() != 0) begin
        front = ld_sb.pop_front();
        check("rnd_ld_order", wd, front);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_we", we, 0);
    check("rst_wa", wa, 0);
    check("rst_wd", wd, 0);
    check("rst_stall", alu_stall, 0);
    check("rst_count", lu_count, 0);
    check("rst_ready", lu_ready, 1);
    rst = 1'b0;

    // ALU only
    drive(1, 6'd5, 32'h1234_5678, 0, 0, 0);
    tick();
    check("alu_we", we, 1);
    check("alu_wa", wa, 5);
    check("alu_wd", wd, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("idle_we", we, 0);
    check("idle_wa_hold", wa, 5);
    check("idle_wd_hold", wd, 32'h1234_5678);

    // Collision: ALU wins, load buffered then written next cycle
    drive(1, 6'd3, 32'hA, 1, 6'd4, 32'hB);
    tick();
    check("col_wa1", wa, 3);
    check("col_wd1", wd, 32'hA);
    check("col_count1", lu_count, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("col_we2", we, 1);
    check("col_wa2", wa, 4);
    check("col_wd2", wd, 32'hB);
    check("col_count2", lu_count, 0);

    // Bypass with empty FIFO
    drive(0, 0, 0, 1, 6'd7, 32'hC);
    tick();
    check("byp_we", we, 1);
    check("byp_wa", wa, 7);
    check("byp_wd", wd, 32'hC);
    check("byp_count", lu_count, 0);

    // Full FIFO and starvation stall
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(10 + i), 32'(i), 1, 6'(20 + i), 32'h100 + 32'(i));
      tick();
      check("full_alu_we", we, 1);
      check("full_alu_wa", wa, 10 + i);
    end
    check("full_count", lu_count, 4);
    check("full_ready", lu_ready, 0);
    check("full_nostall", alu_stall, 0);
    drive(1, 6'd14, 32'hE, 1, 6'd30, 32'h555);
    #1;
    check("full_5th_ready", lu_ready, 0);
    tick();
    check("full_last_alu_wa", wa, 14);
    check("full_stall", alu_stall, 1);
    check("full_count_5th", lu_count, 4);
    tick();
    check("stall_we", we, 1);
    check("stall_wa", wa, 20);
    check("stall_wd", wd, 32'h100);
    check("stall_one_cycle", alu_stall, 0);
    check("stall_count", lu_count, 3);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain_wa", wa, 20 + i);
      check("drain_wd", wd, 32'h100 + 32'(i));
    end
    check("drain_count", lu_count, 0);
    tick();
    check("drain_no_5th", we, 0);

    // Zero register suppression
    drive(1, 6'd0, 32'hFFFF_FFFF, 0, 0, 0);
    tick();
    check("zero_alu_we", we, 0);
    drive(1, 6'd8, 32'h1, 1, 6'd0, 32'hDEAD);
    tick();
    check("zero_alu8_wa", wa, 8);
    check("zero_ld_count1", lu_count, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("zero_ld_we", we, 0);
    check("zero_ld_count0", lu_count, 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'(40 + i), 32'(i), 1, 6'(50 + i), 32'h200 + 32'(i));
      tick();
    end
    check("mrst_pre_count", lu_count, 3);
    check("mrst_pre_we", we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_we", we, 0);
    check("mrst_wa", wa, 0);
    check("mrst_count", lu_count, 0);
    check("mrst_ready", lu_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_post_we1", we, 0);
    tick();
    check("mrst_post_we2", we, 0);
    check("mrst_post_count", lu_count, 0);
    drive(1, 6'd9, 32'h99, 0, 0, 0);
    tick();
    check("mrst_first_we", we, 1);
    check("mrst_first_wa", wa, 9);
    check("mrst_first_wd", wd, 32'h99);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Random traffic against the reference model
    mq.delete();
    ld_sb.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    for (int c = 0; c < 400; c++) model_cycle(1'b0);
    for (int c = 0; c < DEPTH + 3; c++) model_cycle(1'b1);
    check("rnd_sb_drained", ld_sb.size(), 0);
    check("rnd_final_count", lu_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
